// File: rtl/z80_pkg.sv
// Shared Z80 core types used by the interrupt acceptance unit.
package z80_pkg;

    typedef enum logic {
        IRQ_INT = 1'b0,
        IRQ_NMI = 1'b1
    } irq_kind_t;

    typedef enum logic [1:0] {
        IM0 = 2'd0,
        IM1 = 2'd1,
        IM2 = 2'd2
    } im_t;

    localparam logic [1:0] ImReserved = 2'd3;

endpackage

// File: rtl/z80_pin_sync.sv
// Two-flop pin synchronizer (idle high) with an optional falling-edge strobe.
module z80_pin_sync #(
    parameter bit EdgeEn = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic sync,
    output logic fall
);

    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= pin;
            s2_q <= s1_q;
        end
    end

    assign sync = s2_q;

    generate
        if (EdgeEn) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prev_q <= 1'b1;
                end else begin
                    prev_q <= s2_q;
                end
            end

            assign fall = prev_q & ~s2_q;
        end else begin : g_no_edge
            assign fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/z80_irq_unit.sv
// Z80 interrupt acceptance: IFF1/IFF2, IM, delayed EI and request issue to the sequencer.
// The NMI path is built only when Z80_IRQ_NMI_EN is defined.
module z80_irq_unit
    import z80_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       insn_done,
    input  logic       insn_ei,
    input  logic       insn_di,
    input  logic       insn_retn,
    input  logic       im_we,
    input  logic [1:0] im_val,
    input  logic       nmi_n,
    input  logic       int_n,
    input  logic       irq_ack,
    output logic       irq_req,
    output logic       irq_kind,
    output logic [1:0] irq_mode,
    output logic       iff1,
    output logic       iff2,
    output logic [1:0] im,
    output logic       halt_wake
);

    logic      int_sync, int_fall_unused;
    logic      nmi_pend_q, nmi_take;

    logic      iff1_q, iff1_d, iff2_q, iff2_d;
    logic      ei_pend_q, ei_pend_d;
    logic      req_q, req_d;
    irq_kind_t kind_q, kind_d;
    im_t       im_q, im_d, mode_q, mode_d;

    logic      boundary, is_ei, is_di;

    z80_pin_sync #(
        .EdgeEn(1'b0)
    ) u_int_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (int_n),
        .sync   (int_sync),
        .fall   (int_fall_unused)
    );

`ifdef Z80_IRQ_NMI_EN
    logic nmi_sync_unused, nmi_fall;

    z80_pin_sync #(
        .EdgeEn(1'b1)
    ) u_nmi_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .pin    (nmi_n),
        .sync   (nmi_sync_unused),
        .fall   (nmi_fall)
    );

    // A fresh edge arriving on the accept clock stays pending for the next boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nmi_pend_q <= 1'b0;
        end else begin
            nmi_pend_q <= (nmi_pend_q & ~nmi_take) | nmi_fall;
        end
    end
`else
    logic unused_nmi;

    assign nmi_pend_q = 1'b0;
    assign unused_nmi = ^{nmi_n, nmi_take};
`endif

    assign boundary = insn_done & ~req_q;
    assign is_di    = insn_di;
    assign is_ei    = insn_ei & ~insn_di;

    always_comb begin
        iff1_d    = iff1_q;
        iff2_d    = iff2_q;
        ei_pend_d = ei_pend_q;
        im_d      = im_q;
        req_d     = req_q;
        kind_d    = kind_q;
        mode_d    = mode_q;
        nmi_take  = 1'b0;

        if (boundary) begin
            if (ei_pend_q && !is_ei) begin
                iff1_d    = 1'b1;
                iff2_d    = 1'b1;
                ei_pend_d = 1'b0;
            end
            if (is_ei) begin
                ei_pend_d = 1'b1;
            end
            if (is_di) begin
                iff1_d    = 1'b0;
                iff2_d    = 1'b0;
                ei_pend_d = 1'b0;
            end
            if (insn_retn) begin
                iff1_d = iff2_d;
            end
            if (im_we && im_val != ImReserved) begin
                im_d = im_t'(im_val);
            end

            // Acceptance sees the IFF/IM values produced by this instruction.
            if (nmi_pend_q) begin
                nmi_take  = 1'b1;
                kind_d    = IRQ_NMI;
                iff2_d    = iff1_d;
                iff1_d    = 1'b0;
                ei_pend_d = 1'b0;
                req_d     = 1'b1;
                mode_d    = im_d;
            end else if (!int_sync && iff1_d && !is_ei) begin
                kind_d = IRQ_INT;
                iff1_d = 1'b0;
                iff2_d = 1'b0;
                req_d  = 1'b1;
                mode_d = im_d;
            end
        end else if (req_q && irq_ack) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iff1_q    <= 1'b0;
            iff2_q    <= 1'b0;
            ei_pend_q <= 1'b0;
            im_q      <= IM0;
            req_q     <= 1'b0;
            kind_q    <= IRQ_INT;
            mode_q    <= IM0;
        end else begin
            iff1_q    <= iff1_d;
            iff2_q    <= iff2_d;
            ei_pend_q <= ei_pend_d;
            im_q      <= im_d;
            req_q     <= req_d;
            kind_q    <= kind_d;
            mode_q    <= mode_d;
        end
    end

    assign irq_req   = req_q;
    assign irq_kind  = kind_q;
    assign irq_mode  = mode_q;
    assign iff1      = iff1_q;
    assign iff2      = iff2_q;
    assign im        = im_q;
    assign halt_wake = nmi_pend_q | (~int_sync & iff1_q & ~ei_pend_q);

endmodule
